// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
// Shared types and constants for the memory arbiter.
//   arb_state_t     : arbiter FSM states (IDLE, ACCESS)
//   req_id_t        : requester identity (REQ_I instruction fetch, REQ_D data)
//   MEM_LAT_DEFAULT : default number of cycles mem_en is held per access
//   CNT_W           : width of the access-latency counter (covers 1..15)
// -----------------------------------------------------------------------------
package mips_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } arb_state_t;

    typedef enum logic {
        REQ_I = 1'b0,
        REQ_D = 1'b1
    } req_id_t;

    localparam int MEM_LAT_DEFAULT = 2;
    localparam int CNT_W           = 4;

endpackage

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Shares one memory port between an instruction-fetch requester (read only)
// and a data requester (read/write). Round-robin on simultaneous requests,
// one access in flight at a time, each access holds mem_en for MEM_LAT cycles.
//
// Ports
//   clk, reset                 : clock, asynchronous active-low reset
//   i_req, i_addr              : instruction request and address
//   i_gnt, i_rvalid, i_rdata   : instruction grant pulse, read-done pulse, data
//   d_req, d_we, d_addr,
//   d_wdata                    : data request, write enable, address, write data
//   d_gnt, d_rvalid, d_rdata   : data grant pulse, done/ack pulse, read data
//   addr_err                   : pulses with rvalid when the access was unaligned
//   mem_en, mem_addr,
//   mem_wdata, mem_rd_wr       : shared memory port (mem_rd_wr 1 = read)
//   mem_rdata                  : read data from memory
// -----------------------------------------------------------------------------
module mem_arbiter
    import mips_pkg::*;
#(
    parameter int MEM_LAT = MEM_LAT_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_gnt,
    output logic        i_rvalid,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        addr_err,
    output logic        mem_en,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_rd_wr,
    input  logic [31:0] mem_rdata
);

    localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(MEM_LAT - 1);

    arb_state_t       r_state;
    logic [CNT_W-1:0] r_cnt;
    req_id_t          r_last;   // requester granted most recently
    req_id_t          r_owner;  // requester owning the access in flight
    logic             r_we;
    logic [1:0]       r_lsb;    // low address bits kept only for addr_err

    req_id_t          w_win;
    logic             w_any;

    assign w_any = i_req | d_req;

    // On a tie the requester that did not win last time goes next.
    always_comb begin
        w_win = REQ_I;
        if (i_req && d_req) begin
            w_win = (r_last == REQ_I) ? REQ_D : REQ_I;
        end else if (d_req) begin
            w_win = REQ_D;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_last    <= REQ_I;
            r_owner   <= REQ_I;
            r_we      <= 1'b0;
            r_lsb     <= 2'b00;
            i_gnt     <= 1'b0;
            d_gnt     <= 1'b0;
            i_rvalid  <= 1'b0;
            d_rvalid  <= 1'b0;
            i_rdata   <= '0;
            d_rdata   <= '0;
            addr_err  <= 1'b0;
            mem_en    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_rd_wr <= 1'b1;
        end else begin
            // Grant, done and error strobes are single-cycle pulses.
            i_gnt    <= 1'b0;
            d_gnt    <= 1'b0;
            i_rvalid <= 1'b0;
            d_rvalid <= 1'b0;
            addr_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_state <= ACCESS;
                        r_cnt   <= LAT_M1;
                        r_owner <= w_win;
                        r_last  <= w_win;
                        mem_en  <= 1'b1;
                        if (w_win == REQ_D) begin
                            d_gnt     <= 1'b1;
                            r_we      <= d_we;
                            r_lsb     <= d_addr[1:0];
                            mem_addr  <= {d_addr[31:2], 2'b00};
                            mem_wdata <= d_wdata;
                            mem_rd_wr <= ~d_we;
                        end else begin
                            // Instruction fetch never writes; mem_wdata is left as is.
                            i_gnt     <= 1'b1;
                            r_we      <= 1'b0;
                            r_lsb     <= i_addr[1:0];
                            mem_addr  <= {i_addr[31:2], 2'b00};
                            mem_rd_wr <= 1'b1;
                        end
                    end
                end
                ACCESS: begin
                    if (r_cnt == '0) begin
                        r_state   <= IDLE;
                        mem_en    <= 1'b0;
                        mem_rd_wr <= 1'b1;
                        addr_err  <= |r_lsb;
                        if (r_owner == REQ_D) begin
                            d_rvalid <= 1'b1;
                            // A write is acknowledged but leaves d_rdata untouched.
                            if (!r_we) begin
                                d_rdata <= mem_rdata;
                            end
                        end else begin
                            i_rvalid <= 1'b1;
                            i_rdata  <= mem_rdata;
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
    import mips_pkg::*;

    localparam int LAT = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main DUT (MEM_LAT = 2)
    logic        rst_n   = 1'b0;
    logic        i_req   = 1'b0;
    logic [31:0] i_addr  = '0;
    logic        i_gnt, i_rvalid;
    logic [31:0] i_rdata;
    logic        d_req   = 1'b0;
    logic        d_we    = 1'b0;
    logic [31:0] d_addr  = '0;
    logic [31:0] d_wdata = '0;
    logic        d_gnt, d_rvalid;
    logic [31:0] d_rdata;
    logic        addr_err, mem_en, mem_rd_wr;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    // Second DUT (MEM_LAT = 1)
    logic        rst1_n   = 1'b0;
    logic        i_req1   = 1'b0;
    logic [31:0] i_addr1  = '0;
    logic        i_gnt1, i_rvalid1;
    logic [31:0] i_rdata1;
    logic        d_req1   = 1'b0;
    logic        d_we1    = 1'b0;
    logic [31:0] d_addr1  = '0;
    logic [31:0] d_wdata1 = '0;
    logic        d_gnt1, d_rvalid1;
    logic [31:0] d_rdata1;
    logic        addr_err1, mem_en1, mem_rd_wr1;
    logic [31:0] mem_addr1, mem_wdata1, mem_rdata1;

    // Behavioural memory: fixed content per word address, writes are only observed.
    function automatic logic [31:0] mem_f(input logic [31:0] a);
        if (a == 32'h8002_0000) return 32'h3C1D_8012;
        return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
    endfunction

    assign mem_rdata  = mem_f(mem_addr);
    assign mem_rdata1 = mem_f(mem_addr1);

    mem_arbiter #(.MEM_LAT(LAT)) dut (
        .clk(clk), .reset(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .addr_err(addr_err), .mem_en(mem_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rd_wr(mem_rd_wr), .mem_rdata(mem_rdata)
    );

    mem_arbiter #(.MEM_LAT(1)) dut1 (
        .clk(clk), .reset(rst1_n),
        .i_req(i_req1), .i_addr(i_addr1), .i_gnt(i_gnt1), .i_rvalid(i_rvalid1), .i_rdata(i_rdata1),
        .d_req(d_req1), .d_we(d_we1), .d_addr(d_addr1), .d_wdata(d_wdata1),
        .d_gnt(d_gnt1), .d_rvalid(d_rvalid1), .d_rdata(d_rdata1),
        .addr_err(addr_err1), .mem_en(mem_en1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
        .mem_rd_wr(mem_rd_wr1), .mem_rdata(mem_rdata1)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Scoreboard queues
    typedef struct {
        int cyc;
        bit who;            // 0 = instruction, 1 = data
    } gnt_t;
    typedef struct {
        int          cyc;
        bit          who;
        logic        err;
        logic [31:0] ei;    // expected i_rdata after completion
        logic [31:0] ed;    // expected d_rdata after completion
    } resp_t;
    typedef struct {
        logic [31:0] addr;
        logic        rd_wr;
        logic [31:0] wdata;
        bit          chk_wd;
    } memx_t;
    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
    } txn_t;

    gnt_t  gnt_q[$];
    resp_t resp_q[$];
    memx_t mem_q[$];
    bit    gnt_log[$];
    txn_t  iq[$];
    txn_t  dq[$];

    int          cyc    = 0;
    int          busy   = 0;
    bit          last_d = 1'b0;
    logic [31:0] mdl_i  = '0;
    logic [31:0] mdl_d  = '0;
    bit          i_cur  = 1'b0;
    bit          d_cur  = 1'b0;
    bit          rnd_en = 1'b0;

    // Reference model: arbiter is free MEM_LAT+1 edges after each grant edge.
    always @(posedge clk) begin : model
        bit          w;
        bit          wr;
        logic [31:0] a;
        cyc++;
        if (!rst_n) begin
            busy   = 0;
            last_d = 1'b0;
            mdl_i  = '0;
            mdl_d  = '0;
        end else if (busy > 0) begin
            busy--;
        end else if (i_req || d_req) begin
            w      = (i_req && d_req) ? !last_d : d_req;
            last_d = w;
            a      = w ? d_addr : i_addr;
            wr     = w && d_we;
            if (!wr) begin
                if (w) mdl_d = mem_f({a[31:2], 2'b00});
                else   mdl_i = mem_f({a[31:2], 2'b00});
            end
            gnt_q.push_back('{cyc, w});
            mem_q.push_back('{{a[31:2], 2'b00}, !wr, d_wdata, wr});
            resp_q.push_back('{cyc + LAT, w, |a[1:0], mdl_i, mdl_d});
            busy = LAT;
        end
    end

    // Monitor: pops expectations whenever the DUT presents grant/done/memory activity.
    bit    prev_en = 1'b0;
    int    run     = 0;
    memx_t cur_m;

    always @(negedge clk) begin : monitor
        gnt_t  g;
        resp_t r;
        if (!rst_n) begin
            prev_en = 1'b0;
            run     = 0;
        end else begin
            if (i_gnt && d_gnt) check("gnt_overlap", 32'(i_gnt & d_gnt), 32'd0);
            if (i_rvalid && d_rvalid) check("rvalid_overlap", 32'(i_rvalid & d_rvalid), 32'd0);
            if (i_gnt || d_gnt) begin
                gnt_log.push_back(d_gnt);
                if (gnt_q.size() == 0) begin
                    check("gnt_unexpected", 32'(i_gnt | d_gnt), 32'd0);
                end else begin
                    g = gnt_q.pop_front();
                    check("gnt_who", 32'(d_gnt), 32'(g.who));
                    check("gnt_cycle", cyc, g.cyc);
                end
            end
            if (i_rvalid || d_rvalid) begin
                if (resp_q.size() == 0) begin
                    check("rvalid_unexpected", 32'(i_rvalid | d_rvalid), 32'd0);
                end else begin
                    r = resp_q.pop_front();
                    check("rvalid_who", 32'(d_rvalid), 32'(r.who));
                    check("rvalid_cycle", cyc, r.cyc);
                    check("addr_err", 32'(addr_err), 32'(r.err));
                    check("i_rdata", i_rdata, r.ei);
                    check("d_rdata", d_rdata, r.ed);
                    check("en_at_rvalid", 32'(mem_en), 32'd0);
                end
            end else begin
                check("addr_err_alone", 32'(addr_err), 32'd0);
            end
            if (mem_en) begin
                if (!prev_en) begin
                    if (mem_q.size() == 0) begin
                        check("mem_unexpected", 32'(mem_en), 32'd0);
                    end else begin
                        cur_m = mem_q.pop_front();
                        check("mem_addr", mem_addr, cur_m.addr);
                        check("mem_rd_wr", 32'(mem_rd_wr), 32'(cur_m.rd_wr));
                        if (cur_m.chk_wd) check("mem_wdata", mem_wdata, cur_m.wdata);
                    end
                    run = 1;
                end else begin
                    run++;
                    check("mem_addr_hold", mem_addr, cur_m.addr);
                    check("mem_rd_wr_hold", 32'(mem_rd_wr), 32'(cur_m.rd_wr));
                end
            end else begin
                if (prev_en) check("mem_en_len", run, LAT);
                check("idle_rd_wr", 32'(mem_rd_wr), 32'd1);
            end
            prev_en = mem_en;
        end
    end

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        a = $urandom;
        if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
        return a;
    endfunction

    // Requester agents: hold req and operands until gnt is seen, then pick the next.
    always @(negedge clk) begin : agent_i
        txn_t t;
        if (!rst_n) begin
            i_req = 1'b0;
            i_cur = 1'b0;
        end else begin
            if (i_cur && i_gnt) begin
                i_cur = 1'b0;
                i_req = 1'b0;
            end
            if (!i_cur) begin
                if (iq.size() > 0) begin
                    t      = iq.pop_front();
                    i_addr = t.addr;
                    i_req  = 1'b1;
                    i_cur  = 1'b1;
                end else if (rnd_en && $urandom_range(0, 3) == 0) begin
                    i_addr = rand_addr();
                    i_req  = 1'b1;
                    i_cur  = 1'b1;
                end else begin
                    i_req = 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin : agent_d
        txn_t t;
        if (!rst_n) begin
            d_req = 1'b0;
            d_cur = 1'b0;
        end else begin
            if (d_cur && d_gnt) begin
                d_cur = 1'b0;
                d_req = 1'b0;
            end
            if (!d_cur) begin
                if (dq.size() > 0) begin
                    t       = dq.pop_front();
                    d_addr  = t.addr;
                    d_we    = t.we;
                    d_wdata = t.wdata;
                    d_req   = 1'b1;
                    d_cur   = 1'b1;
                end else if (rnd_en && $urandom_range(0, 2) == 0) begin
                    d_addr  = rand_addr();
                    d_we    = 1'($urandom_range(0, 1));
                    d_wdata = $urandom;
                    d_req   = 1'b1;
                    d_cur   = 1'b1;
                end else begin
                    d_req = 1'b0;
                end
            end
        end
    end

    task automatic flush();
        gnt_q.delete();
        resp_q.delete();
        mem_q.delete();
        gnt_log.delete();
        iq.delete();
        dq.delete();
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((i_cur || d_cur || busy != 0 || iq.size() != 0 || dq.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        total++;
        if (n >= budget) begin
            bad++;
            $display("FAIL idle_timeout: waited %0d cycles, limit %0d", n, budget);
        end
        check("queues_drained", gnt_q.size() + resp_q.size() + mem_q.size(), 0);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, got t=%0t", $time);
        $fatal(1, "watchdog expired");
    end

    logic [31:0] a1 [4] = '{32'h8002_0000, 32'h0000_1000, 32'h1234_5678, 32'hCAFE_0040};

    initial begin : main
        int n;
        logic [31:0] ra;
        repeat (2) @(negedge clk);

        // Reset values
        check("rst_i_gnt", 32'(i_gnt), 32'd0);
        check("rst_d_gnt", 32'(d_gnt), 32'd0);
        check("rst_i_rvalid", 32'(i_rvalid), 32'd0);
        check("rst_d_rvalid", 32'(d_rvalid), 32'd0);
        check("rst_addr_err", 32'(addr_err), 32'd0);
        check("rst_mem_en", 32'(mem_en), 32'd0);
        check("rst_mem_rd_wr", 32'(mem_rd_wr), 32'd1);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_i_rdata", i_rdata, 32'd0);
        check("rst_d_rdata", d_rdata, 32'd0);

        // Instruction read
        rst_n = 1'b1;
        iq.push_back('{32'h8002_0000, 1'b0, 32'h0});
        wait_idle(50);
        check("ifetch_rdata", i_rdata, 32'h3C1D_8012);

        // Data write, then unaligned data read
        dq.push_back('{32'h8011_FFFC, 1'b1, 32'hDEAD_BEEF});
        wait_idle(50);
        check("write_keeps_d_rdata", d_rdata, 32'd0);
        dq.push_back('{32'h8012_0002, 1'b0, 32'h0});
        wait_idle(50);
        check("unaligned_rdata", d_rdata, mem_f(32'h8012_0000));

        // Both requesters busy from reset: D, I, D, I
        @(negedge clk);
        rst_n = 1'b0;
        flush();
        iq.push_back('{32'h0000_0100, 1'b0, 32'h0});
        iq.push_back('{32'h0000_0104, 1'b0, 32'h0});
        dq.push_back('{32'h0000_0200, 1'b0, 32'h0});
        dq.push_back('{32'h0000_0204, 1'b1, 32'h1111_2222});
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_idle(60);
        check("tie_count", gnt_log.size(), 4);
        if (gnt_log.size() == 4) begin
            check("tie_order0", 32'(gnt_log[0]), 32'd1);
            check("tie_order1", 32'(gnt_log[1]), 32'd0);
            check("tie_order2", 32'(gnt_log[2]), 32'd1);
            check("tie_order3", 32'(gnt_log[3]), 32'd0);
        end

        // Reset during the first ACCESS cycle aborts the access
        iq.push_back('{32'h0000_0300, 1'b0, 32'h0});
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!mem_en && n < 20);
        check("abort_reached_access", 32'(mem_en), 32'd1);
        rst_n = 1'b0;
        flush();
        #1;
        check("abort_mem_en", 32'(mem_en), 32'd0);
        check("abort_i_gnt", 32'(i_gnt), 32'd0);
        check("abort_mem_rd_wr", 32'(mem_rd_wr), 32'd1);
        check("abort_mem_addr", mem_addr, 32'd0);
        check("abort_i_rdata", i_rdata, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        ra = 32'h0000_0400;
        iq.push_back('{ra, 1'b0, 32'h0});
        wait_idle(50);
        check("after_abort_rdata", i_rdata, mem_f(ra));

        // Random traffic from both requesters
        rnd_en = 1'b1;
        repeat (600) @(negedge clk);
        rnd_en = 1'b0;
        wait_idle(200);

        // MEM_LAT = 1: back-to-back instruction reads
        i_addr1 = a1[0];
        i_req1  = 1'b1;
        @(negedge clk);
        check("lat1_rst_mem_en", 32'(mem_en1), 32'd0);
        check("lat1_rst_rvalid", 32'(i_rvalid1), 32'd0);
        rst1_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("lat1_mem_en", 32'(mem_en1), 32'(k % 2 == 0));
            check("lat1_gnt", 32'(i_gnt1), 32'(k % 2 == 0));
            check("lat1_rvalid", 32'(i_rvalid1), 32'(k % 2 == 1));
            if (k % 2 == 1) begin
                check("lat1_rdata", i_rdata1, mem_f(a1[k / 2]));
            end else begin
                check("lat1_mem_addr", mem_addr1, a1[k / 2]);
                i_addr1 = a1[k / 2 + 1];
            end
        end
        i_req1 = 1'b0;
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter MEM_LAT, default 2, the number of cycles mem_en is held per access (legal range 1..15).
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have ports i_req in 1, i_addr in 32, i_gnt out 1, i_rvalid out 1, i_rdata out 32  for the instruction-fetch requester, which only reads.
REQ-005 SHALL have ports d_req in 1, d_we in 1, d_addr in 32, d_wdata in 32, d_gnt out 1, d_rvalid out 1, d_rdata out 32  for the data requester.
REQ-006 SHALL have port addr_err  output  1  pulsed when the completing access had addr[1:0] != 0.
REQ-007 SHALL have ports mem_en out 1, mem_addr out 32, mem_wdata out 32, mem_rd_wr out 1 (1 = read), mem_rdata in 32  as the single shared memory port.

Function
REQ-008 SHALL implement FSM states IDLE and ACCESS only.
REQ-009 In IDLE, on an edge where i_req or d_req is high, SHALL go to ACCESS, latch the winner's address, we and wdata, and load the counter with MEM_LAT-1.
REQ-010 When both requests are high at once, SHALL grant the requester not granted last (round-robin); the last-grant pointer resets to "instruction", so data wins the first tie.
REQ-011 SHALL assert the winner's gnt, registered, for exactly the one cycle after the arbitration edge; the requester holds req (and its addr/wdata) until it samples gnt.
REQ-012 In ACCESS, SHALL drive mem_en=1, mem_addr = {latched addr[31:2], 2'b00}, mem_rd_wr = ~we and mem_wdata = latched wdata, for exactly MEM_LAT cycles.
REQ-013 On the edge where the counter is 0 in ACCESS, SHALL capture mem_rdata into the winner's rdata, go to IDLE, and pulse the winner's rvalid for one cycle.
REQ-014 SHALL hold rdata stable until the next completion for that requester.
REQ-015 For a data write, d_rvalid SHALL still pulse as the write acknowledge, and d_rdata SHALL remain unchanged.
REQ-016 Arbitration SHALL be allowed in the cycle rvalid is high, so back-to-back accesses have exactly one idle cycle with mem_en=0; req-sampled edge to rvalid is MEM_LAT+1 cycles.
REQ-017 SHALL ignore requests while in ACCESS; they wait in IDLE with no loss and no duplicate grant.
REQ-018 SHALL pulse addr_err together with rvalid when the latched addr[1:0] != 0; the aligned access still completes.
REQ-019 While idle, SHALL hold mem_en=0 and mem_rd_wr=1, with mem_addr and mem_wdata retaining their last values.
REQ-020 SHALL never assert i_gnt and d_gnt, or i_rvalid and d_rvalid, in the same cycle.
REQ-021 When the counter wraps at MEM_LAT=1, SHALL give single-cycle ACCESS with no underflow.

Reset
REQ-022 On reset low, SHALL immediately set: state IDLE, counter 0, pointer = instruction, all gnt/rvalid/addr_err/mem_en = 0, mem_rd_wr = 1, all data/address outputs = 0.
REQ-023 Reset mid-ACCESS SHALL abort the access with no rvalid or acknowledge; the first arbitration happens on the first edge after reset deasserts.

Structure
REQ-024 The shared package mips_pkg SHALL hold the arb_state_t enum (IDLE, ACCESS), the requester-id type (REQ_I, REQ_D) and the MEM_LAT default constant.
REQ-025 The module SHALL be flat; no sub-module is warranted.

Verification
REQ-026 Instruction read, MEM_LAT=2: i_req with i_addr=80020000, mem_rdata=3C1D8012 -> i_gnt one cycle, mem_en two cycles, read; i_rvalid on the 3rd edge after request with i_rdata=3C1D8012.
REQ-027 Data write: d_we=1, d_addr=8011FFFC, d_wdata=DEADBEEF -> mem_rd_wr=0 with those values for MEM_LAT cycles; d_rvalid pulse; d_rdata unchanged.
REQ-028 Simultaneous i_req and d_req held from reset -> grant order D, I, D, I; one idle cycle between accesses; gnt and rvalid never overlap.
REQ-029 d_addr=80120002, read -> mem_addr=80120000; addr_err and d_rvalid pulse together.
REQ-030 Reset asserted in the 1st ACCESS cycle -> mem_en drops at once, no rvalid; a request after release is served normally.
REQ-031 MEM_LAT=1 back-to-back instruction reads -> mem_en pattern 1,0,1,0; each rvalid 2 cycles after its sampled request.
